// File: rtl/icache_pkg.sv
// Shared encodings and defaults for the direct-mapped instruction cache.
// Holds the FSM state codes, the state enum and default geometry.
package icache_pkg;

  localparam logic [1:0] ICACHE_IDLE = 2'd0;
  localparam logic [1:0] ICACHE_MISS = 2'd1;
  localparam logic [1:0] ICACHE_DROP = 2'd2;

  localparam int ICACHE_INDEX_W = 6;
  localparam int ICACHE_ADDR_W  = 18;

  typedef enum logic [1:0] {
    ST_IDLE = ICACHE_IDLE,
    ST_MISS = ICACHE_MISS,
    ST_DROP = ICACHE_DROP
  } icache_state_t;

  function automatic int icache_tag_w(
    input int addr_w,
    input int index_w
  );
    return addr_w - index_w - 2;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read by index, one sync write.
// Ports: clk_in, rst_in (clears valid), rd_* read side, wr_* fill side.
import icache_pkg::*;

module icache_array #(
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int TAG_W   = 10
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: valid gates every use.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped one-word-line icache between IF and the memory fetch port.
// Ports: clk_in/rst_in/rdy_in/roll_back, IF side (fetch_start, pc,
// finish_fetch, instruction_out), memory side (mem_fetch_start, mem_pc,
// mem_finish, mem_instruction); ICACHE_STATS_EN adds hit/miss_count.
import icache_pkg::*;

module icache_direct #(
  parameter int INDEX_W = ICACHE_INDEX_W,
  parameter int ADDR_W  = ICACHE_ADDR_W
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        roll_back,
  input  logic        fetch_start,
  input  logic [31:0] pc,
  output logic        finish_fetch,
  output logic [31:0] instruction_out,
  output logic        mem_fetch_start,
  output logic [31:0] mem_pc,
  input  logic        mem_finish,
  input  logic [31:0] mem_instruction
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int TAG_W = icache_tag_w(ADDR_W, INDEX_W);

  icache_state_t state_q, state_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          finish_q, finish_d;
  logic [31:0]   instr_q, instr_d;
  logic          mreq_q, mreq_d;

  logic [INDEX_W-1:0] lu_idx, fill_idx;
  logic [TAG_W-1:0]   lu_tag, fill_tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [31:0]        rd_data;
  logic               hit;
  logic               wr_en;
  logic               acc_hit, acc_miss;

  assign lu_idx   = pc[INDEX_W+1:2];
  assign lu_tag   = pc[ADDR_W-1:INDEX_W+2];
  assign fill_idx = req_pc_q[INDEX_W+1:2];
  assign fill_tag = req_pc_q[ADDR_W-1:INDEX_W+2];

  logic unused_addr;
  assign unused_addr = ^{pc[31:ADDR_W], pc[1:0],
                         req_pc_q[31:ADDR_W], req_pc_q[1:0]};

  icache_array #(
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_array (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rd_idx  (lu_idx),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (fill_idx),
    .wr_tag  (fill_tag),
    .wr_data (mem_instruction)
  );

  assign hit = rd_valid && (rd_tag == lu_tag);

  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    finish_d = 1'b0;
    instr_d  = instr_q;
    mreq_d   = mreq_q;
    wr_en    = 1'b0;
    acc_hit  = 1'b0;
    acc_miss = 1'b0;
    if (rdy_in) begin
      unique case (state_q)
        ST_IDLE: begin
          // finish_q blocks re-accepting a request IF has not dropped yet
          if (fetch_start && !finish_q) begin
            if (hit) begin
              acc_hit  = 1'b1;
              finish_d = !roll_back;
              if (!roll_back) instr_d = rd_data;
            end else if (!roll_back) begin
              acc_miss = 1'b1;
              req_pc_d = pc;
              mreq_d   = 1'b1;
              state_d  = ST_MISS;
            end
          end
        end
        ST_MISS: begin
          if (mem_finish) begin
            wr_en   = 1'b1;
            mreq_d  = 1'b0;
            state_d = ST_IDLE;
            if (!roll_back) begin
              finish_d = 1'b1;
              instr_d  = mem_instruction;
            end
          end else if (roll_back) begin
            // memory cannot abort; wait it out silently
            state_d = ST_DROP;
          end
        end
        ST_DROP: begin
          if (mem_finish) begin
            wr_en   = 1'b1;
            mreq_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          mreq_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      req_pc_q <= '0;
      finish_q <= 1'b0;
      instr_q  <= '0;
      mreq_q   <= 1'b0;
    end else if (rdy_in) begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      finish_q <= finish_d;
      instr_q  <= instr_d;
      mreq_q   <= mreq_d;
    end
  end

  assign finish_fetch    = finish_q;
  assign instruction_out = instr_q;
  assign mem_fetch_start = mreq_q;
  assign mem_pc          = req_pc_q;

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (rdy_in) begin
      if (acc_hit)  hit_count  <= hit_count + 32'd1;
      if (acc_miss) miss_count <= miss_count + 32'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = acc_hit ^ acc_miss;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus a
// randomized fetch stream checked against a line-address cache model.
module tb_icache_direct;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, roll_back, fetch_start;
  logic [31:0] pc;
  logic        finish_fetch;
  logic [31:0] instruction_out;
  logic        mem_fetch_start;
  logic [31:0] mem_pc;
  logic        mem_finish;
  logic [31:0] mem_instruction;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int checks = 0;
  int passed = 0;

  bit          rv [64];
  logic [15:0] rl [64];
  logic [31:0] rd [64];
  int          ref_hits, ref_misses;

  icache_direct dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .roll_back      (roll_back),
    .fetch_start    (fetch_start),
    .pc             (pc),
    .finish_fetch   (finish_fetch),
    .instruction_out(instruction_out),
    .mem_fetch_start(mem_fetch_start),
    .mem_pc         (mem_pc),
    .mem_finish     (mem_finish),
    .mem_instruction(mem_instruction)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a[17:0])
      18'h00010: return 32'h0000_0513;
      18'h00110: return 32'hFFF0_0093;
      18'h00020: return 32'h0010_0113;
      default:   return {a[31:18] ^ 14'h2a5, a[17:2], 2'b11};
    endcase
  endfunction

  // Runs one IF request; memory answers after lat cycles of request.
  // gap==1 means the response came one cycle after the deciding event.
  task automatic fetch(
    input  logic [31:0] a,
    input  int          lat,
    output logic        was_miss,
    output logic [31:0] data,
    output logic [31:0] mpc,
    output int          gap,
    output bit          tmo
  );
    int mreq;
    int fin_n;
    bit done;
    mreq = 0; fin_n = -1; done = 0;
    was_miss = 0; data = '0; mpc = '0; gap = -1;
    fetch_start = 1'b1;
    pc = a;
    for (int n = 0; n < 100 && !done; n++) begin
      tick();
      mem_finish = 1'b0;
      if (finish_fetch) begin
        done = 1;
        data = instruction_out;
        gap = n - fin_n;
        fetch_start = 1'b0;
      end else if (mem_fetch_start) begin
        if (mreq == 0) mpc = mem_pc;
        was_miss = 1;
        mreq++;
        if (mreq == lat) begin
          mem_finish = 1'b1;
          mem_instruction = mem_word(mem_pc);
          fin_n = n;
        end
      end
    end
    fetch_start = 1'b0;
    tmo = !done;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; roll_back = 1'b0;
    fetch_start = 1'b0; pc = '0;
    mem_finish = 1'b0; mem_instruction = '0;
    tick(); tick();
    rst_in = 1'b0;
    tick();
    checks++;
    if (finish_fetch !== 1'b0)
      $display("FAIL reset_finish: got %b want 0", finish_fetch);
    else passed++;
    checks++;
    if (mem_fetch_start !== 1'b0)
      $display("FAIL reset_mreq: got %b want 0", mem_fetch_start);
    else passed++;
    checks++;
    if (instruction_out !== 32'h0)
      $display("FAIL reset_instr: got %h want 0", instruction_out);
    else passed++;
    checks++;
    if (mem_pc !== 32'h0)
      $display("FAIL reset_mem_pc: got %h want 0", mem_pc);
    else passed++;
`ifdef ICACHE_STATS_EN
    checks++;
    if (hit_count !== 0 || miss_count !== 0)
      $display("FAIL reset_stats: got %0d/%0d want 0/0",
               hit_count, miss_count);
    else passed++;
`endif
  endtask

  task automatic test_cold_miss();
    logic m; logic [31:0] d, mp; int g; bit t;
    fetch(32'h10, 6, m, d, mp, g, t);
    checks++;
    if (t || !m || mp !== 32'h10)
      $display("FAIL cold_miss_req: tmo %0b miss %0b mem_pc %h want miss 0x10",
               t, m, mp);
    else passed++;
    checks++;
    if (d !== 32'h0000_0513 || g != 1)
      $display("FAIL cold_miss_data: got %h gap %0d want 00000513 gap 1",
               d, g);
    else passed++;
    tick();
    checks++;
    if (finish_fetch !== 1'b0)
      $display("FAIL cold_miss_pulse: finish %b want 0", finish_fetch);
    else passed++;
  endtask

  task automatic test_hit();
    logic m; logic [31:0] d, mp; int g; bit t;
    fetch(32'h10, 3, m, d, mp, g, t);
    checks++;
    if (t || m || d !== 32'h0000_0513 || g != 1)
      $display("FAIL hit: tmo %0b miss %0b data %h gap %0d want hit 00000513 gap 1",
               t, m, d, g);
    else passed++;
    tick();
  endtask

  task automatic test_conflict_stall();
    logic m; logic [31:0] d, mp; int g; bit t;
    bit ok;
    fetch_start = 1'b1; pc = 32'h110;
    tick();
    checks++;
    if (mem_fetch_start !== 1'b1 || mem_pc !== 32'h110)
      $display("FAIL conflict_miss: mreq %b mem_pc %h want 1 00000110",
               mem_fetch_start, mem_pc);
    else passed++;
    tick();
    mem_finish = 1'b1;
    mem_instruction = 32'hFFF0_0093;
    rdy_in = 1'b0;
    ok = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_fetch_start !== 1'b1 || finish_fetch !== 1'b0 ||
          mem_pc !== 32'h110) ok = 0;
    end
    checks++;
    if (!ok)
      $display("FAIL stall_hold: mreq %b finish %b mem_pc %h want 1 0 110",
               mem_fetch_start, finish_fetch, mem_pc);
    else passed++;
    rdy_in = 1'b1;
    tick();
    mem_finish = 1'b0;
    fetch_start = 1'b0;
    checks++;
    if (finish_fetch !== 1'b1 || instruction_out !== 32'hFFF0_0093 ||
        mem_fetch_start !== 1'b0)
      $display("FAIL stall_resume: finish %b instr %h mreq %b want 1 fff00093 0",
               finish_fetch, instruction_out, mem_fetch_start);
    else passed++;
    tick();
    fetch(32'h10, 2, m, d, mp, g, t);
    checks++;
    if (t || !m || d !== 32'h0000_0513)
      $display("FAIL conflict_remiss: tmo %0b miss %0b data %h want miss 00000513",
               t, m, d);
    else passed++;
    tick();
  endtask

  task automatic test_roll_back_miss();
    logic m; logic [31:0] d, mp; int g; bit t;
    fetch_start = 1'b1; pc = 32'h20;
    tick();
    tick(); tick();
    roll_back = 1'b1; fetch_start = 1'b0;
    tick();
    roll_back = 1'b0;
    checks++;
    if (mem_fetch_start !== 1'b1 || finish_fetch !== 1'b0)
      $display("FAIL drop_hold: mreq %b finish %b want 1 0",
               mem_fetch_start, finish_fetch);
    else passed++;
    tick(); tick();
    mem_finish = 1'b1;
    mem_instruction = 32'h0010_0113;
    tick();
    mem_finish = 1'b0;
    checks++;
    if (finish_fetch !== 1'b0 || mem_fetch_start !== 1'b0)
      $display("FAIL drop_fill: finish %b mreq %b want 0 0",
               finish_fetch, mem_fetch_start);
    else passed++;
    tick();
    checks++;
    if (finish_fetch !== 1'b0)
      $display("FAIL drop_no_finish: finish %b want 0", finish_fetch);
    else passed++;
    fetch(32'h20, 2, m, d, mp, g, t);
    checks++;
    if (t || m || d !== 32'h0010_0113)
      $display("FAIL drop_then_hit: tmo %0b miss %0b data %h want hit 00100113",
               t, m, d);
    else passed++;
    tick();
`ifdef ICACHE_STATS_EN
    checks++;
    if (hit_count !== 2 || miss_count !== 4)
      $display("FAIL stats_plan: got %0d/%0d want 2/4",
               hit_count, miss_count);
    else passed++;
`endif
  endtask

  task automatic test_roll_back_same_cycle();
    logic m; logic [31:0] d, mp; int g; bit t;
    fetch_start = 1'b1; pc = 32'h30;
    tick();
    fetch_start = 1'b0;
    roll_back = 1'b1;
    mem_finish = 1'b1;
    mem_instruction = mem_word(32'h30);
    tick();
    roll_back = 1'b0;
    mem_finish = 1'b0;
    checks++;
    if (finish_fetch !== 1'b0 || mem_fetch_start !== 1'b0)
      $display("FAIL rb_fin_same: finish %b mreq %b want 0 0",
               finish_fetch, mem_fetch_start);
    else passed++;
    tick();
    fetch(32'h30, 2, m, d, mp, g, t);
    checks++;
    if (t || m || d !== mem_word(32'h30))
      $display("FAIL rb_fin_filled: tmo %0b miss %0b data %h want hit %h",
               t, m, d, mem_word(32'h30));
    else passed++;
    tick();
  endtask

  task automatic test_roll_back_hit();
    fetch_start = 1'b1; pc = 32'h10;
    roll_back = 1'b1;
    tick();
    roll_back = 1'b0;
    fetch_start = 1'b0;
    checks++;
    if (finish_fetch !== 1'b0 || mem_fetch_start !== 1'b0)
      $display("FAIL rb_hit: finish %b mreq %b want 0 0",
               finish_fetch, mem_fetch_start);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid_miss();
    logic m; logic [31:0] d, mp; int g; bit t;
    fetch_start = 1'b1; pc = 32'h40;
    tick();
    fetch_start = 1'b0;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    mem_finish = 1'b1;
    mem_instruction = 32'hDEAD_BEEF;
    tick();
    mem_finish = 1'b0;
    checks++;
    if (finish_fetch !== 1'b0 || mem_fetch_start !== 1'b0)
      $display("FAIL late_finish: finish %b mreq %b want 0 0",
               finish_fetch, mem_fetch_start);
    else passed++;
    fetch(32'h10, 2, m, d, mp, g, t);
    checks++;
    if (t || !m || d !== 32'h0000_0513)
      $display("FAIL reset_invalidates: tmo %0b miss %0b data %h want miss 00000513",
               t, m, d);
    else passed++;
    tick();
    for (int i = 0; i < 64; i++) rv[i] = 0;
    rv[4] = 1; rl[4] = 16'h0004; rd[4] = 32'h0000_0513;
    ref_hits = 0; ref_misses = 1;
  endtask

  task automatic test_random();
    logic m; logic [31:0] d, mp; int g; bit t;
    logic [31:0] a, r;
    int idx, lat;
    bit exp_miss;
    logic [31:0] exp_d;
    for (int it = 0; it < 80; it++) begin
      r = $urandom();
      a = (r & 32'hFFFC_0000) |
          (32'($urandom_range(0, 3)) << 10) |
          (32'($urandom_range(0, 7)) << 2) |
          32'($urandom_range(0, 3));
      lat = $urandom_range(1, 4);
      idx = int'(a[7:2]);
      exp_miss = !(rv[idx] && rl[idx] == a[17:2]);
      exp_d = exp_miss ? mem_word(a) : rd[idx];
      fetch(a, lat, m, d, mp, g, t);
      checks++;
      if (t || m !== exp_miss || d !== exp_d || g != 1 ||
          (exp_miss && mp !== a))
        $display("FAIL rand[%0d] pc %h: tmo %0b miss %0b data %h mem_pc %h gap %0d want miss %0b data %h",
                 it, a, t, m, d, mp, g, exp_miss, exp_d);
      else passed++;
      if (exp_miss) begin
        rv[idx] = 1; rl[idx] = a[17:2]; rd[idx] = exp_d;
        ref_misses++;
      end else begin
        ref_hits++;
      end
      tick();
    end
`ifdef ICACHE_STATS_EN
    checks++;
    if (hit_count !== ref_hits || miss_count !== ref_misses)
      $display("FAIL stats_rand: got %0d/%0d want %0d/%0d",
               hit_count, miss_count, ref_hits, ref_misses);
    else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict_stall();
    test_roll_back_miss();
    test_roll_back_same_cycle();
    test_roll_back_hit();
    test_reset_mid_miss();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, one-word-per-line instruction cache between the instruction-fetch stage (upstream) and the memory controller fetch port (downstream).
- On a hit it returns the instruction from its tag/data arrays with no memory traffic.
- On a miss it issues one word fetch to the memory controller, fills the line, then returns the word.
- It absorbs pipeline roll-back without corrupting fill state.

Parameters:
- INDEX_W, 6, index bits; LINES = 2^INDEX_W.
- ADDR_W, 18, significant address bits (pc[17:0]); tag = pc[ADDR_W-1:INDEX_W+2].

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- rdy_in  input  1  when low, freeze all state; outputs hold.
- roll_back  input  1  pipeline flush from the ROB.
- fetch_start  input  1  IF requests instruction at pc (level; sampled only in IDLE).
- pc  input  32  fetch address, word aligned.
- finish_fetch  output  1  one-cycle pulse; instruction_out valid.
- instruction_out  output  32  fetched instruction.
- mem_fetch_start  output  1  request to memory controller, held until mem_finish.
- mem_pc  output  32  address of miss request.
- mem_finish  input  1  memory controller word-complete pulse.
- mem_instruction  input  32  word returned with mem_finish.

Behaviour:
- Reset: all valid bits 0, state IDLE, finish_fetch=0, mem_fetch_start=0, instruction_out=0, mem_pc=0.
- rdy_in=0: no state, array, or output register changes. roll_back is ignored while rdy_in=0.
- The FSM has three states: IDLE, MISS, DROP.
- IDLE, fetch_start=1, valid[idx]=1, tag match (hit):
  - Next cycle: finish_fetch=1, instruction_out=data[idx].
  - State stays IDLE.
  - Hit latency is 1 cycle.
- IDLE, fetch_start=1, miss:
  - Latch req_pc=pc.
  - Next cycle: mem_fetch_start=1, mem_pc=req_pc, state MISS.
- MISS, mem_finish=1:
  - Write data[idx]=mem_instruction, tag, valid=1.
  - mem_fetch_start=0.
  - Next cycle: finish_fetch=1, instruction_out=mem_instruction, state IDLE.
- finish_fetch is high exactly one cycle per accepted request.
- No new request is accepted in the cycle finish_fetch is high. IF must deassert fetch_start on seeing finish_fetch.
- roll_back=1 in IDLE: any pending hit response for the next cycle is suppressed (finish_fetch=0).
- roll_back=1 in MISS with no mem_finish this cycle:
  - The memory transaction cannot be aborted, so keep mem_fetch_start high and go to DROP.
- DROP:
  - On mem_finish, fill the line normally, but do not assert finish_fetch.
  - Return to IDLE.
- roll_back and mem_finish in the same cycle in MISS: fill the line, suppress finish_fetch, go to IDLE.
- In DROP, fetch_start is ignored. IF re-requests after returning to IDLE.
- Fill and lookup of the same index in the same cycle cannot occur, because lookups happen only in IDLE.
- pc[1:0] is ignored.
- Reset mid-MISS:
  - All state clears.
  - A late mem_finish arriving in IDLE is ignored; the memory controller is reset by the same rst_in.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0].
  - Counts increment on each accepted IDLE request (hit or miss). Roll-back-dropped requests still count.
  - Counters reset to 0, freeze when rdy_in=0, and wrap at 2^32.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header (alongside existing operaType.v defines): ICACHE_IDLE/ICACHE_MISS/ICACHE_DROP state encodings (2 bits) and the default INDEX_W.
- One sub-module, icache_array: valid/tag/data storage with combinational read by index and a synchronous single write port with reset-clear of valid bits.
- The FSM and handshakes stay in icache_direct.

Test Plan:
- Cold miss:
  - Stimulus: reset, fetch_start with pc=0x0000_0010; mem_finish arrives 5 cycles after mem_fetch_start with 0x0000_0513.
  - Required: mem_pc=0x10; finish_fetch pulses once with 0x0000_0513, one cycle after mem_finish.
- Hit:
  - Stimulus: repeat pc=0x10.
  - Required: no mem_fetch_start; finish_fetch the next cycle with 0x0000_0513.
- Conflict:
  - Stimulus: fill 0x10, then fetch 0x110 (same index 4, different tag), returning 0xFFF0_0093; then fetch 0x10 again.
  - Required: both 0x110 and the repeated 0x10 miss.
- Roll-back mid-miss:
  - Stimulus: miss on 0x20, assert roll_back 2 cycles later; mem_finish returns 0x0010_0113.
  - Required: no finish_fetch; a later fetch of 0x20 hits with 0x0010_0113.
- rdy_in stall:
  - Stimulus: drop rdy_in for 3 cycles during MISS while mem_finish is held by the memory side.
  - Required: state, mem_fetch_start and outputs unchanged; resumes correctly afterwards.
- Stats (ICACHE_STATS_EN):
  - Stimulus: the sequence above.
  - Required: hit_count=2, miss_count=4.
